// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan controller.
// Holds the FSM encoding and the mux geometry.
package mux_scan_pkg;

  localparam int NUM_INPUTS = 4;
  localparam int ADDR_W     = 2;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/settle_timer.sv
// Settle-cycle down counter: load, decrement, expire flag.
// Ports: clk, rst_n (sync), load/load_val, dec, expire (count <= 1).
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // Expires in the last settle cycle so the edge that closes it
  // moves the FSM on to SAMPLE.
  assign expire = (count <= CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_scan_controller.sv
// Drives a test word through a 4:1 mux and reads it back per address.
// Ports: clk, rst_n, start, word_in -> in0..in3, address0/1, busy, done,
// word_out, match; mux_out is the mux output fed back for sampling.
module mux_scan_controller
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] word_in,
  output logic       in0,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       address0,
  output logic       address1,
  input  logic       mux_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] word_out,
  output logic       match
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INPUTS - 1);

  state_t                  state;
  logic [ADDR_W-1:0]       addr;
  logic [NUM_INPUTS-1:0]   data;
  logic [NUM_INPUTS-1:0]   cap;
  logic [NUM_INPUTS-1:0]   cap_next;
  logic                    t_load;
  logic                    t_dec;
  logic                    expire;

  assign {in3, in2, in1, in0} = data;
  assign {address1, address0} = addr;

  always_comb begin
    cap_next       = cap;
    cap_next[addr] = mux_out;
  end

  // Reload on acceptance and on every address step.
  assign t_load = (state == IDLE && start) ||
                  (state == SAMPLE && addr != LAST_ADDR);
  assign t_dec  = (state == SETTLE) && !expire;

  settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .dec      (t_dec),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      data     <= '0;
      cap      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_out <= '0;
      match    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            data  <= word_in;
            addr  <= '0;
            cap   <= '0;
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (expire) state <= SAMPLE;
        end
        SAMPLE: begin
          cap <= cap_next;
          if (addr == LAST_ADDR) begin
            word_out <= cap_next;
            match    <= (cap_next == data);
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            addr  <= addr + ADDR_W'(1);
            state <= SETTLE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_controller.sv
// Self-checking bench for mux_scan_controller with an attached mux model.
// Expected words are queued at start and checked when done pulses.
module tb_mux_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] word_in = 4'h0;
  logic       mux_out;
  logic       in0, in1, in2, in3;
  logic       address0, address1;
  logic       busy, done, match;
  logic [3:0] word_out;
  logic [3:0] dl;
  bit         stuck = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] word;
    logic       match;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mux_scan_controller #(.SETTLE_CYCLES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .word_in  (word_in),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .address0 (address0),
    .address1 (address1),
    .mux_out  (mux_out),
    .busy     (busy),
    .done     (done),
    .word_out (word_out),
    .match    (match)
  );

  assign dl = {in3, in2, in1, in0};

  always_comb begin
    mux_out = 1'b0;
    if (!stuck) mux_out = dl[{address1, address0}];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] w);
    exp_t e;
    e.word  = stuck ? 4'b0000 : w;
    e.match = (e.word == w);
    sb.push_back(e);
  endtask

  // Caller must be in an IDLE cycle; returns at cycle 0 of the scan.
  task automatic accept(input logic [3:0] w);
    word_in = w;
    start   = 1'b1;
    push_exp(w);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 200);
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    start   = 1'b1;
    word_in = 4'hF;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if ({dl, address1, address0, busy, done, word_out, match} !== 13'd0) begin
        miscompares++;
        $display("FAIL reset[%0d]: in=%b addr=%b%b busy=%b done=%b wo=%b m=%b, required all 0",
                 i, dl, address1, address0, busy, done, word_out, match);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    sb.delete();
    tick();
  endtask

  task automatic test_loopback;
    exp_t e;
    accept(4'b1010);
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if ({address1, address0} !== 2'(c / 3) || busy !== 1'b1 ||
          done !== 1'b0 || dl !== 4'b1010) begin
        miscompares++;
        $display("FAIL loopback_c%0d: addr=%b%b busy=%b done=%b in=%b, required addr=%0d busy=1 done=0 in=1010",
                 c, address1, address0, busy, done, dl, c / 3);
      end
      tick();
    end
    e = sb.pop_front();
    vectors++;
    if (done !== 1'b1 || word_out !== e.word || match !== e.match) begin
      miscompares++;
      $display("FAIL loopback_done: done=%b wo=%b m=%b, required done=1 wo=%b m=%b",
               done, word_out, match, e.word, e.match);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL loopback_idle: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_fault;
    exp_t e;
    int   n;
    stuck = 1'b1;
    accept(4'b1111);
    wait_done(n);
    e = sb.pop_front();
    vectors++;
    if (done !== 1'b1 || n !== 12) begin
      miscompares++;
      $display("FAIL fault_latency: done=%b cycles=%0d, required 1 12", done, n);
    end
    vectors++;
    if (word_out !== e.word || match !== e.match) begin
      miscompares++;
      $display("FAIL fault_word: wo=%b m=%b, required wo=%b m=%b",
               word_out, match, e.word, e.match);
    end
    stuck = 1'b0;
    repeat (4) tick();
    vectors++;
    if (word_out !== e.word || match !== e.match) begin
      miscompares++;
      $display("FAIL fault_hold: wo=%b m=%b, required wo=%b m=%b",
               word_out, match, e.word, e.match);
    end
  endtask

  task automatic test_busy_ignore;
    exp_t       e;
    int         ndone;
    logic [3:0] seen;
    ndone = 0;
    seen  = 4'hx;
    accept(4'b0110);
    tick();
    word_in = 4'b1001;
    start   = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (dl !== 4'b0110 || {address1, address0} !== 2'b00) begin
      miscompares++;
      $display("FAIL ignore_lines: in=%b addr=%b%b, required in=0110 addr=00",
               dl, address1, address0);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        seen = word_out;
      end
    end
    e = sb.pop_front();
    vectors++;
    if (ndone !== 1 || seen !== e.word) begin
      miscompares++;
      $display("FAIL ignore_done: pulses=%0d wo=%b, required pulses=1 wo=%b",
               ndone, seen, e.word);
    end
  endtask

  task automatic test_reset_midscan;
    exp_t e;
    int   n;
    accept(4'b1100);
    repeat (8) tick();
    vectors++;
    if ({address1, address0} !== 2'b10) begin
      miscompares++;
      $display("FAIL midscan_addr: addr=%b%b, required 10", address1, address0);
    end
    rst_n = 1'b0;
    tick();
    vectors++;
    if ({dl, address1, address0, busy, done, word_out, match} !== 13'd0) begin
      miscompares++;
      $display("FAIL midscan_reset: in=%b addr=%b%b busy=%b done=%b wo=%b m=%b, required all 0",
               dl, address1, address0, busy, done, word_out, match);
    end
    sb.delete();
    rst_n = 1'b1;
    accept(4'b0011);
    wait_done(n);
    e = sb.pop_front();
    vectors++;
    if (done !== 1'b1 || n !== 12 || word_out !== e.word || match !== e.match) begin
      miscompares++;
      $display("FAIL midscan_rescan: done=%b cycles=%0d wo=%b m=%b, required 1 12 %b %b",
               done, n, word_out, match, e.word, e.match);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n;
    word_in = 4'b0101;
    start   = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(4'b0101);
    tick();
    for (int k = 0; k < 3; k++) begin
      wait_done(n);
      if (k == 2) start = 1'b0;
      e = sb.pop_front();
      vectors++;
      if (done !== 1'b1 || n !== (k == 0 ? 12 : 14) ||
          word_out !== e.word || match !== e.match) begin
        miscompares++;
        $display("FAIL b2b_%0d: done=%b gap=%0d wo=%b m=%b, required 1 %0d %b %b",
                 k, done, n, word_out, match, (k == 0 ? 12 : 14), e.word, e.match);
      end
    end
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_stop: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_fault();
    test_busy_ignore();
    test_reset_midscan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
